alpha_packet_capture: RTL and testbench
=======================================

// Module: alpha_packet_capture
// PURPOSE
//  Downstream consumer of the ALPHA serial-readout word stream (16-bit words with header/footer flags).
//  Assembles words into packets and buffers them in a dual-pointer FIFO; commits only complete packets.
//  Drops malformed, oversize, timed-out or overflowing packets.
//  Presents committed packets on a valid/ready word interface for the host/readout path.
//  Input stream must be synchronous to clock100.
// PARAMETERS
//  ADDR_WIDTH        9     buffer depth = 2**ADDR_WIDTH entries of {last,word[15:0]}
//  MAX_PACKET_WORDS  258   max words per packet, header and footer included
//  TIMEOUT_CYCLES    4096  max clock100 cycles between strobes inside a packet
//  COUNTER_WIDTH     16    width of status counters
// PORTS
//  clock100          in   1   system clock, 100 MHz
//  reset             in   1   synchronous, active-high
//  in_strobe         in   1   one-cycle pulse: in_word/in_header/in_footer valid
//  in_word           in   16  completed readout word
//  in_header         in   1   word is a packet header (sampled with in_strobe)
//  in_footer         in   1   word is a packet footer (sampled with in_strobe)
//  rd_ready          in   1   consumer accepts rd_word this cycle
//  rd_valid          out  1   rd_word/rd_last hold a committed entry
//  rd_word           out  16  buffered word
//  rd_last           out  1   rd_word is the final (footer) word of its packet
//  packets_pending   out  ADDR_WIDTH+1  committed packets not yet fully read
//  accepted_count    out  COUNTER_WIDTH  packets committed, saturating
//  dropped_count     out  COUNTER_WIDTH  packets discarded, saturating
//  stray_count       out  COUNTER_WIDTH  strobes outside any packet, saturating
//  capturing         out  1   FSM in BODY
// BEHAVIOUR
//  Reset: all outputs 0; rptr = wptr_commit = wptr_spec = 0; FSM to IDLE; buffered data discarded.
//  Reset mid-packet or mid-read: the same, no partial packet survives.
//  Pointers are ADDR_WIDTH+1 bits, wrap modulo 2**(ADDR_WIDTH+1); free = DEPTH - (wptr_spec - rptr).
//  FSM states IDLE, BODY, DROP. len = words written in the current packet.
//  IDLE, strobe & header & footer: write {1,word}, commit; single-word packet.
//  IDLE, strobe & header: write {0,word} at wptr_commit; wptr_spec = wptr_commit+1; len=1; go BODY.
//  IDLE, strobe & !header: stray_count++.
//  BODY, strobe & header: abandon current packet (dropped++); restart from this header, as in IDLE.
//  BODY, strobe & footer: write {1,word}, commit; accepted++; go IDLE.
//  BODY, strobe (otherwise): write {0,word}; len++.
//  BODY, write would overflow free space or make len > MAX_PACKET_WORDS: wptr_spec = wptr_commit.
//    After that rewind: dropped++, go DROP.
//  BODY, no strobe for TIMEOUT_CYCLES consecutive cycles: rewind, dropped++, go IDLE.
//  DROP: ignore words; footer strobe -> IDLE; header strobe -> restart as in IDLE (no extra drop count).
//  Commit: wptr_commit = address after footer entry, in the cycle following the footer strobe.
//    packets_pending++ in that same cycle.
//  Read: first-word-fall-through. rd_valid = 1 while rptr != wptr_commit.
//    rd_valid rises <=2 cycles after the commit cycle.
//    Transfer on rd_valid & rd_ready; the next entry is presented next cycle.
//    Sustained 1 word/cycle. rd_word/rd_last stable while rd_valid & !rd_ready.
//  Transfer with rd_last: packets_pending--. Commit and last-read in the same cycle leave it unchanged.
//  Uncommitted words are never visible on rd_*; the reader cannot pass wptr_commit.
//  Counters saturate at all-ones; never wrap.
//  Strobe back-to-back every cycle is legal; no words lost while free space remains.
// TESTING
//  1: strobes H(0x8001), 0x1234, 0x5678, F(0xF00D), rd_ready=1.
//     -> rd_* yields 8001,1234,5678,F00D; rd_last only on F00D; accepted=1; pending 1->0.
//  2: H, 3 words, then H, 1 word, F.
//     -> dropped=1, accepted=1; output only the second packet (3 words).
//  3: ADDR_WIDTH=4, rd_ready=0, packets of 6 words until full.
//     -> 2 packets committed, 3rd dropped; rd_valid never exposes partial 3rd.
//  4: H + 300 body words + F.
//     -> dropped=1, DROP entered at word 259, accepted unchanged, buffer empty.
//  5: H, 2 words, idle 4096 cycles.
//     -> dropped=1, FSM IDLE, rd_valid=0; a 5 strobes-without-header test -> stray=5.
//  6: reset asserted mid-packet with 1 committed packet unread.
//     -> next cycle rd_valid=0, all counters/pending 0, FSM IDLE.

Source files
------------

// File: rtl/alpha_packet_capture.sv
// ALPHA readout packet capture: assembles header/body/footer words into packets, buffers
// complete packets only, and presents them on a first-word-fall-through valid/ready port.
module alpha_packet_capture #(
  parameter int ADDR_WIDTH       = 9,
  parameter int MAX_PACKET_WORDS = 258,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int COUNTER_WIDTH    = 16
) (
  input  logic                     clock100,
  input  logic                     reset,
  input  logic                     in_strobe,
  input  logic [15:0]              in_word,
  input  logic                     in_header,
  input  logic                     in_footer,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [15:0]              rd_word,
  output logic                     rd_last,
  output logic [ADDR_WIDTH:0]      packets_pending,
  output logic [COUNTER_WIDTH-1:0] accepted_count,
  output logic [COUNTER_WIDTH-1:0] dropped_count,
  output logic [COUNTER_WIDTH-1:0] stray_count,
  output logic                     capturing
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int LEN_W = $clog2(MAX_PACKET_WORDS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W-1:0]         PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]         PTR_DEPTH = PTR_W'(DEPTH);
  localparam logic [LEN_W-1:0]         LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]         LEN_MAX   = LEN_W'(MAX_PACKET_WORDS);
  localparam logic [TO_W-1:0]          TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0]          TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t           state;
  logic [16:0]      mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr_commit, wptr_spec;
  logic [LEN_W-1:0] len;
  logic [TO_W-1:0]  idle_cnt;

  logic [PTR_W-1:0]      used_spec, used_commit;
  logic                  space_spec, space_commit, word_ok, header_strobe, timeout;
  logic                  mem_we, commit_evt, drop_evt, stray_evt, last_read;
  logic [ADDR_WIDTH-1:0] mem_addr;

  // rptr counts the entry already moved into the output register as freed
  assign used_spec     = wptr_spec - rptr;
  assign used_commit   = wptr_commit - rptr;
  assign space_spec    = (used_spec != PTR_DEPTH);
  assign space_commit  = (used_commit != PTR_DEPTH);
  assign word_ok       = space_spec && (len < LEN_MAX);
  assign header_strobe = in_strobe && in_header;
  assign timeout       = (state == BODY) && (idle_cnt == TO_LAST);
  assign last_read     = rd_valid && rd_ready && rd_last;
  assign capturing     = (state == BODY);

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = wptr_spec[ADDR_WIDTH-1:0];
    commit_evt = 1'b0;
    drop_evt   = 1'b0;
    stray_evt  = 1'b0;
    if (header_strobe) begin
      // a header always restarts at the committed boundary, discarding any open packet
      mem_addr = wptr_commit[ADDR_WIDTH-1:0];
      if (state == BODY) drop_evt = 1'b1;
      if (space_commit) begin
        mem_we     = 1'b1;
        commit_evt = in_footer;
      end else if (state != BODY) begin
        drop_evt = 1'b1;
      end
    end else if (in_strobe) begin
      case (state)
        IDLE: stray_evt = 1'b1;
        BODY: begin
          if (word_ok) begin
            mem_we     = 1'b1;
            commit_evt = in_footer;
          end else begin
            drop_evt = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeout) begin
      drop_evt = 1'b1;
    end
  end

  always_ff @(posedge clock100) begin
    if (mem_we) mem[mem_addr] <= {in_footer, in_word};
  end

  always_ff @(posedge clock100) begin
    if (reset) begin
      state       <= IDLE;
      wptr_commit <= '0;
      wptr_spec   <= '0;
      len         <= '0;
      idle_cnt    <= '0;
    end else if (header_strobe) begin
      idle_cnt <= '0;
      if (!space_commit) begin
        wptr_spec <= wptr_commit;
        len       <= '0;
        state     <= in_footer ? IDLE : DROP;
      end else if (in_footer) begin
        wptr_commit <= wptr_commit + PTR_ONE;
        wptr_spec   <= wptr_commit + PTR_ONE;
        len         <= '0;
        state       <= IDLE;
      end else begin
        wptr_spec <= wptr_commit + PTR_ONE;
        len       <= LEN_ONE;
        state     <= BODY;
      end
    end else begin
      case (state)
        BODY: begin
          if (in_strobe) begin
            idle_cnt <= '0;
            if (!word_ok) begin
              wptr_spec <= wptr_commit;
              len       <= '0;
              state     <= DROP;
            end else if (in_footer) begin
              wptr_commit <= wptr_spec + PTR_ONE;
              wptr_spec   <= wptr_spec + PTR_ONE;
              len         <= '0;
              state       <= IDLE;
            end else begin
              wptr_spec <= wptr_spec + PTR_ONE;
              len       <= len + LEN_ONE;
            end
          end else if (timeout) begin
            wptr_spec <= wptr_commit;
            len       <= '0;
            idle_cnt  <= '0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + TO_ONE;
          end
        end
        DROP: begin
          if (in_strobe && in_footer) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  // Output register refills whenever it is empty or being consumed, giving 1 word/cycle
  always_ff @(posedge clock100) begin
    if (reset) begin
      rptr     <= '0;
      rd_valid <= 1'b0;
      rd_word  <= '0;
      rd_last  <= 1'b0;
    end else if (!rd_valid || rd_ready) begin
      if (rptr != wptr_commit) begin
        {rd_last, rd_word} <= mem[rptr[ADDR_WIDTH-1:0]];
        rd_valid           <= 1'b1;
        rptr               <= rptr + PTR_ONE;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock100) begin
    if (reset) begin
      packets_pending <= '0;
      accepted_count  <= '0;
      dropped_count   <= '0;
      stray_count     <= '0;
    end else begin
      if (commit_evt && !last_read)
        packets_pending <= packets_pending + PTR_ONE;
      else if (!commit_evt && last_read)
        packets_pending <= packets_pending - PTR_ONE;
      if (commit_evt && accepted_count != '1) accepted_count <= accepted_count + CNT_ONE;
      if (drop_evt && dropped_count != '1)    dropped_count  <= dropped_count + CNT_ONE;
      if (stray_evt && stray_count != '1)     stray_count    <= stray_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alpha_packet_capture.sv
// Bench for alpha_packet_capture: vector table, directed corner sequences and a
// randomized run against a packet-level reference model.
module tb_alpha_packet_capture;

  logic        clock100 = 1'b0;
  logic        reset;
  logic        in_strobe, in_header, in_footer, rd_ready;
  logic [15:0] in_word;
  logic        rd_valid, rd_last, capturing;
  logic [15:0] rd_word, accepted_count, dropped_count, stray_count;
  logic [9:0]  packets_pending;

  logic        s_strobe, s_header, s_footer, s_ready;
  logic [15:0] s_word;
  logic        s_rd_valid, s_rd_last, s_capturing;
  logic [15:0] s_rd_word, s_accepted, s_dropped, s_stray;
  logic [4:0]  s_pending;

  int checks = 0;
  int failures = 0;

  always #5 clock100 = ~clock100;

  alpha_packet_capture dut (
    .clock100(clock100), .reset(reset), .in_strobe(in_strobe), .in_word(in_word),
    .in_header(in_header), .in_footer(in_footer), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_word(rd_word), .rd_last(rd_last),
    .packets_pending(packets_pending), .accepted_count(accepted_count),
    .dropped_count(dropped_count), .stray_count(stray_count), .capturing(capturing)
  );

  alpha_packet_capture #(.ADDR_WIDTH(4)) small_dut (
    .clock100(clock100), .reset(reset), .in_strobe(s_strobe), .in_word(s_word),
    .in_header(s_header), .in_footer(s_footer), .rd_ready(s_ready),
    .rd_valid(s_rd_valid), .rd_word(s_rd_word), .rd_last(s_rd_last),
    .packets_pending(s_pending), .accepted_count(s_accepted),
    .dropped_count(s_dropped), .stray_count(s_stray), .capturing(s_capturing)
  );

  typedef struct {
    logic        strobe, header, footer;
    logic [15:0] word;
    logic        ready, chk_rd, exp_valid;
    logic [15:0] exp_word;
    logic        exp_last;
    int          exp_pend, exp_acc, exp_drop;
    logic        exp_cap;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] expq[$];
  int          m_pend;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic f, input logic [15:0] w, input logic rdy);
    in_strobe = s; in_header = h; in_footer = f; in_word = w; rd_ready = rdy;
  endtask

  task automatic applySmall(input logic s, input logic h, input logic f, input logic [15:0] w, input logic rdy);
    s_strobe = s; s_header = h; s_footer = f; s_word = w; s_ready = rdy;
  endtask

  task automatic addVec(input logic s, input logic h, input logic f, input logic [15:0] w, input logic rdy,
                        input logic chk, input logic ev, input logic [15:0] ew, input logic el,
                        input int ep, input int ea, input int ed, input logic ec);
    vec_t v;
    v.strobe = s; v.header = h; v.footer = f; v.word = w; v.ready = rdy;
    v.chk_rd = chk; v.exp_valid = ev; v.exp_word = ew; v.exp_last = el;
    v.exp_pend = ep; v.exp_acc = ea; v.exp_drop = ed; v.exp_cap = ec;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 16'h0, 0);
    applySmall(0, 0, 0, 16'h0, 0);
    reset = 1'b1;
    @(negedge clock100);
    reset = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock100);
  endtask

  task automatic checkTransfer();
    logic [16:0] exp;
    if (expq.size() == 0) begin
      checkOutput("rnd_no_word_expected", {31'b0, rd_valid}, 32'd0);
    end else begin
      exp = expq.pop_front();
      checkOutput("rnd_word", {15'b0, rd_last, rd_word}, {15'b0, exp});
      if (exp[16]) m_pend--;
    end
  endtask

  // Reference model: tracks the open packet as a word list and pushes whole packets on footer
  task automatic runRandom(input int n_cycles);
    logic [15:0] cur[$];
    logic        s, h, f, rdy, lastflag;
    logic [15:0] w;
    bit          in_pkt;
    int          target, acc, drp, stry, r;
    in_pkt = 0; target = 2; acc = 0; drp = 0; stry = 0; m_pend = 0;
    expq.delete();
    for (int c = 0; c <= n_cycles; c++) begin
      rdy = ($urandom_range(0, 99) < 70);
      s = 0; h = 0; f = 0; w = 16'($urandom);
      if (c == n_cycles) begin
        s = in_pkt; f = in_pkt;
      end else if ($urandom_range(0, 99) < 60) begin
        r = $urandom_range(0, 99);
        if (!in_pkt) begin
          if (expq.size() < 400) begin
            s = 1;
            if (r < 12) f = r[0];
            else begin h = 1; f = (r < 20); end
          end
        end else begin
          s = 1;
          if (r < 4) h = 1;
          else if (cur.size() + 1 >= target) f = 1;
        end
      end
      applyStimulus(s, h, f, w, rdy);
      if (rd_valid && rdy) checkTransfer();
      if (s) begin
        if (h) begin
          if (in_pkt) drp++;
          cur.delete();
          target = $urandom_range(2, 12);
        end
        if (!h && !in_pkt) begin
          stry++;
        end else begin
          cur.push_back(w);
          in_pkt = 1;
          if (f) begin
            for (int i = 0; i < cur.size(); i++) begin
              lastflag = (i == cur.size() - 1);
              expq.push_back({lastflag, cur[i]});
            end
            acc++; m_pend++;
            in_pkt = 0;
          end
        end
      end
      @(negedge clock100);
    end
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(0, 0, 0, 16'h0, 1);
      if (rd_valid) checkTransfer();
      else if (expq.size() == 0) break;
      @(negedge clock100);
    end
    checkOutput("rnd_drained", expq.size(), 32'd0);
    checkOutput("rnd_rd_valid_idle", {31'b0, rd_valid}, 32'd0);
    checkOutput("rnd_accepted", {16'b0, accepted_count}, acc);
    checkOutput("rnd_dropped", {16'b0, dropped_count}, drp);
    checkOutput("rnd_stray", {16'b0, stray_count}, stry);
    checkOutput("rnd_pending", {22'b0, packets_pending}, m_pend);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [16:0] exp;
    int got;

    reset = 1'b1;
    applyStimulus(0, 0, 0, 16'h0, 0);
    applySmall(0, 0, 0, 16'h0, 0);
    idleCycles(3);
    checkOutput("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    checkOutput("reset_rd_word", {16'b0, rd_word}, 32'd0);
    checkOutput("reset_pending", {22'b0, packets_pending}, 32'd0);
    checkOutput("reset_accepted", {16'b0, accepted_count}, 32'd0);
    checkOutput("reset_stray", {16'b0, stray_count}, 32'd0);
    checkOutput("reset_capturing", {31'b0, capturing}, 32'd0);
    checkOutput("reset_small_valid", {31'b0, s_rd_valid}, 32'd0);
    reset = 1'b0;

    // s h f word rdy | chk valid word last | pend acc drop cap
    addVec(1,1,0,16'h8001,0, 1,0,16'h0000,0, 0,0,0,1);
    addVec(1,0,0,16'h1234,0, 1,0,16'h0000,0, 0,0,0,1);
    addVec(1,0,0,16'h5678,0, 1,0,16'h0000,0, 0,0,0,1);
    addVec(1,0,1,16'hF00D,0, 0,0,16'h0000,0, 1,1,0,0);
    addVec(0,0,0,16'h0000,0, 0,0,16'h0000,0, 1,1,0,0);
    addVec(0,0,0,16'h0000,0, 1,1,16'h8001,0, 1,1,0,0);
    addVec(0,0,0,16'h0000,1, 1,1,16'h1234,0, 1,1,0,0);
    addVec(0,0,0,16'h0000,1, 1,1,16'h5678,0, 1,1,0,0);
    addVec(0,0,0,16'h0000,1, 1,1,16'hF00D,1, 1,1,0,0);
    addVec(0,0,0,16'h0000,1, 1,0,16'h0000,0, 0,1,0,0);
    addVec(1,1,0,16'hA000,0, 1,0,16'h0000,0, 0,1,0,1);
    addVec(1,0,0,16'hA001,0, 1,0,16'h0000,0, 0,1,0,1);
    addVec(1,0,0,16'hA002,0, 1,0,16'h0000,0, 0,1,0,1);
    addVec(1,0,0,16'hA003,0, 1,0,16'h0000,0, 0,1,0,1);
    addVec(1,1,0,16'hB000,0, 1,0,16'h0000,0, 0,1,1,1);
    addVec(1,0,0,16'hB001,0, 1,0,16'h0000,0, 0,1,1,1);
    addVec(1,0,1,16'hB002,0, 0,0,16'h0000,0, 1,2,1,0);
    addVec(0,0,0,16'h0000,0, 0,0,16'h0000,0, 1,2,1,0);
    addVec(0,0,0,16'h0000,0, 1,1,16'hB000,0, 1,2,1,0);
    addVec(0,0,0,16'h0000,1, 1,1,16'hB001,0, 1,2,1,0);
    addVec(0,0,0,16'h0000,1, 1,1,16'hB002,1, 1,2,1,0);
    addVec(0,0,0,16'h0000,1, 1,0,16'h0000,0, 0,2,1,0);

    @(negedge clock100);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].strobe, vecs[i].header, vecs[i].footer, vecs[i].word, vecs[i].ready);
      @(negedge clock100);
      checkOutput($sformatf("vec%0d_pending", i), {22'b0, packets_pending}, vecs[i].exp_pend);
      checkOutput($sformatf("vec%0d_accepted", i), {16'b0, accepted_count}, vecs[i].exp_acc);
      checkOutput($sformatf("vec%0d_dropped", i), {16'b0, dropped_count}, vecs[i].exp_drop);
      checkOutput($sformatf("vec%0d_capturing", i), {31'b0, capturing}, {31'b0, vecs[i].exp_cap});
      if (vecs[i].chk_rd) begin
        checkOutput($sformatf("vec%0d_rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].exp_valid});
        if (vecs[i].exp_valid)
          checkOutput($sformatf("vec%0d_rd_data", i), {15'b0, rd_last, rd_word},
                      {15'b0, vecs[i].exp_last, vecs[i].exp_word});
      end
    end

    // Oversize packet: the 259th word must push the FSM into DROP
    doReset();
    applyStimulus(1, 1, 0, 16'h4000, 0);
    @(negedge clock100);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1, 0, 0, 16'h4000 + 16'(i), 0);
      @(negedge clock100);
      if (i == 257) begin
        checkOutput("t4_capturing_at_258", {31'b0, capturing}, 32'd1);
        checkOutput("t4_dropped_at_258", {16'b0, dropped_count}, 32'd0);
      end
      if (i == 258) begin
        checkOutput("t4_capturing_at_259", {31'b0, capturing}, 32'd0);
        checkOutput("t4_dropped_at_259", {16'b0, dropped_count}, 32'd1);
      end
    end
    applyStimulus(1, 0, 1, 16'h4FFF, 0);
    @(negedge clock100);
    applyStimulus(0, 0, 0, 16'h0, 1);
    idleCycles(3);
    checkOutput("t4_dropped", {16'b0, dropped_count}, 32'd1);
    checkOutput("t4_accepted", {16'b0, accepted_count}, 32'd0);
    checkOutput("t4_stray", {16'b0, stray_count}, 32'd0);
    checkOutput("t4_rd_valid", {31'b0, rd_valid}, 32'd0);
    checkOutput("t4_pending", {22'b0, packets_pending}, 32'd0);

    // Inter-word timeout, then strays
    doReset();
    applyStimulus(1, 1, 0, 16'h5000, 0); @(negedge clock100);
    applyStimulus(1, 0, 0, 16'h5001, 0); @(negedge clock100);
    applyStimulus(1, 0, 0, 16'h5002, 0); @(negedge clock100);
    applyStimulus(0, 0, 0, 16'h0, 1);
    idleCycles(4090);
    checkOutput("t5_capturing_before_timeout", {31'b0, capturing}, 32'd1);
    idleCycles(10);
    checkOutput("t5_capturing_after_timeout", {31'b0, capturing}, 32'd0);
    checkOutput("t5_dropped", {16'b0, dropped_count}, 32'd1);
    checkOutput("t5_rd_valid", {31'b0, rd_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 16'h5100 + 16'(i), 1);
      @(negedge clock100);
    end
    applyStimulus(0, 0, 0, 16'h0, 1);
    @(negedge clock100);
    checkOutput("t5_stray", {16'b0, stray_count}, 32'd5);
    checkOutput("t5_capturing_after_strays", {31'b0, capturing}, 32'd0);

    // Reset in the middle of a packet with a committed packet unread
    doReset();
    applyStimulus(1, 1, 0, 16'h6000, 0); @(negedge clock100);
    applyStimulus(1, 0, 0, 16'h6001, 0); @(negedge clock100);
    applyStimulus(1, 0, 1, 16'h6002, 0); @(negedge clock100);
    applyStimulus(0, 0, 0, 16'h0, 0);
    idleCycles(3);
    applyStimulus(1, 1, 0, 16'h6100, 0); @(negedge clock100);
    applyStimulus(1, 0, 0, 16'h6101, 0); @(negedge clock100);
    checkOutput("t6_pending_before", {22'b0, packets_pending}, 32'd1);
    checkOutput("t6_capturing_before", {31'b0, capturing}, 32'd1);
    doReset();
    checkOutput("t6_rd_valid", {31'b0, rd_valid}, 32'd0);
    checkOutput("t6_pending", {22'b0, packets_pending}, 32'd0);
    checkOutput("t6_accepted", {16'b0, accepted_count}, 32'd0);
    checkOutput("t6_capturing", {31'b0, capturing}, 32'd0);
    idleCycles(3);
    checkOutput("t6_rd_valid_later", {31'b0, rd_valid}, 32'd0);

    // Small buffer: 6-word packets until full, third one must be dropped
    doReset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 6; i++) begin
        applySmall(1, i == 0, i == 5, 16'h3000 + 16'(p * 16 + i), 0);
        @(negedge clock100);
      end
    applySmall(0, 0, 0, 16'h0, 0);
    idleCycles(3);
    checkOutput("t3_accepted", {16'b0, s_accepted}, 32'd2);
    checkOutput("t3_dropped", {16'b0, s_dropped}, 32'd1);
    checkOutput("t3_pending", {27'b0, s_pending}, 32'd2);
    checkOutput("t3_stray", {16'b0, s_stray}, 32'd0);
    got = 0;
    for (int k = 0; k < 100 && got < 12; k++) begin
      applySmall(0, 0, 0, 16'h0, 1);
      if (s_rd_valid) begin
        exp[16]   = (got % 6 == 5);
        exp[15:0] = 16'h3000 + 16'((got / 6) * 16 + got % 6);
        checkOutput($sformatf("t3_word%0d", got), {15'b0, s_rd_last, s_rd_word}, {15'b0, exp});
        got++;
      end
      @(negedge clock100);
    end
    checkOutput("t3_words_read", got, 32'd12);
    idleCycles(3);
    checkOutput("t3_no_partial_visible", {31'b0, s_rd_valid}, 32'd0);
    checkOutput("t3_pending_drained", {27'b0, s_pending}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      applySmall(1, i == 0, i == 5, 16'h3300 + 16'(i), 0);
      @(negedge clock100);
    end
    applySmall(0, 0, 0, 16'h0, 0);
    idleCycles(2);
    checkOutput("t3_accepted_after_drain", {16'b0, s_accepted}, 32'd3);
    checkOutput("t3_pending_after_drain", {27'b0, s_pending}, 32'd1);

    doReset();
    runRandom(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
